// File: rtl/rxuart_ctrl.sv
// rxuart_ctrl: owns the rxuart setup word, sequences rxuart resets on setup change, buffers bytes+flags in a FIFO.
// Optional idle timeout behind RXUART_CTRL_TIMEOUT_EN; without it o_rx_timeout is tied low.
module rxuart_ctrl #(
  parameter int          LGFLEN        = 4,
  parameter logic [30:0] INITIAL_SETUP = 31'd868
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_setup_wr,
  input  logic [30:0]       i_setup,
  input  logic              i_flush,
  input  logic              i_clr_status,
  output logic [30:0]       o_rx_setup,
  output logic              o_rx_reset,
  input  logic              i_rx_wr,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_break,
  input  logic              i_rx_parity_err,
  input  logic              i_rx_frame_err,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [7:0]        o_data,
  output logic              o_perr,
  output logic              o_ferr,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_half_full,
  output logic              o_overrun,
  output logic              o_break_seen,
  output logic              o_rx_timeout
);
  localparam int DEPTH = 1 << LGFLEN;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RELEASE} state_t;

  state_t              r_state;
  logic                r_rx_reset;
  logic [30:0]         r_setup;
  logic [9:0]          r_mem [DEPTH];
  logic [LGFLEN-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LGFLEN:0]     r_fill;
  logic                r_brk_prev, r_break_seen, r_overrun;

  logic                w_valid, w_full, w_pop, w_push_req, w_push, w_drop, w_brk_rise;
  logic [9:0]          w_head;

  // A setup write at any point restarts the two-cycle rxuart reset window.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_HOLD;
      r_rx_reset <= 1'b1;
      r_setup    <= INITIAL_SETUP;
    end else if (i_setup_wr) begin
      r_setup    <= i_setup;
      r_state    <= S_HOLD;
      r_rx_reset <= 1'b1;
    end else begin
      case (r_state)
        S_HOLD: begin
          r_state    <= S_RELEASE;
          r_rx_reset <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_rx_reset <= 1'b0;
        end
      endcase
    end
  end

  assign w_valid    = (r_fill != '0);
  assign w_full     = (r_fill == (LGFLEN+1)'(DEPTH));
  assign w_pop      = w_valid && i_ready;
  assign w_push_req = i_rx_wr && (r_state == S_IDLE);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_brk_rise = i_rx_break && !r_brk_prev;

  // When full, wr_ptr == rd_ptr: a push+pop reuses the slot being popped.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush)
      r_mem[r_wr_ptr] <= {i_rx_frame_err, i_rx_parity_err, i_rx_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LGFLEN'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LGFLEN'(1);
      if (w_push && !w_pop)      r_fill <= r_fill + (LGFLEN+1)'(1);
      else if (w_pop && !w_push) r_fill <= r_fill - (LGFLEN+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_brk_prev   <= 1'b0;
      r_break_seen <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_brk_prev <= i_rx_break;
      if (w_brk_rise)        r_break_seen <= 1'b1;
      else if (i_clr_status) r_break_seen <= 1'b0;
      if (w_drop)            r_overrun <= 1'b1;
      else if (i_clr_status) r_overrun <= 1'b0;
    end
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign o_valid      = w_valid;
  assign o_data       = w_valid ? w_head[7:0] : 8'h00;
  assign o_perr       = w_valid && w_head[8];
  assign o_ferr       = w_valid && w_head[9];
  assign o_fill       = r_fill;
  assign o_half_full  = (r_fill >= (LGFLEN+1)'(DEPTH / 2));
  assign o_overrun    = r_overrun;
  assign o_break_seen = r_break_seen;
  assign o_rx_setup   = r_setup;
  assign o_rx_reset   = r_rx_reset;

`ifdef RXUART_CTRL_TIMEOUT_EN
  logic [27:0] r_to_cnt;
  logic [27:0] w_to_max;

  // Saturates at 16 baud periods; clamps down if setup shrinks the limit.
  assign w_to_max = {r_setup[23:0], 4'h0};

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_to_cnt <= '0;
    else if (w_push || w_pop || i_flush || !w_valid)
      r_to_cnt <= '0;
    else if (r_to_cnt >= w_to_max)
      r_to_cnt <= w_to_max;
    else
      r_to_cnt <= r_to_cnt + 28'd1;
  end

  assign o_rx_timeout = (r_to_cnt == w_to_max) && w_valid;
`else
  assign o_rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rxuart_ctrl.sv
// Scoreboard bench for rxuart_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_rxuart_ctrl;
  logic        i_clk = 1'b0;
  logic        i_reset, i_setup_wr, i_flush, i_clr_status;
  logic [30:0] i_setup, o_rx_setup;
  logic        o_rx_reset;
  logic        i_rx_wr, i_rx_break, i_rx_parity_err, i_rx_frame_err;
  logic [7:0]  i_rx_data, o_data;
  logic        o_valid, i_ready, o_perr, o_ferr;
  logic [4:0]  o_fill;
  logic        o_half_full, o_overrun, o_break_seen, o_rx_timeout;

  always #5 i_clk = ~i_clk;

  rxuart_ctrl #(.LGFLEN(4), .INITIAL_SETUP(31'd868)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_setup_wr(i_setup_wr), .i_setup(i_setup),
    .i_flush(i_flush), .i_clr_status(i_clr_status), .o_rx_setup(o_rx_setup),
    .o_rx_reset(o_rx_reset), .i_rx_wr(i_rx_wr), .i_rx_data(i_rx_data),
    .i_rx_break(i_rx_break), .i_rx_parity_err(i_rx_parity_err),
    .i_rx_frame_err(i_rx_frame_err), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_perr(o_perr), .o_ferr(o_ferr), .o_fill(o_fill),
    .o_half_full(o_half_full), .o_overrun(o_overrun), .o_break_seen(o_break_seen),
    .o_rx_timeout(o_rx_timeout)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: entry count, remaining reset-window cycles, sticky bits, expected byte queue.
  int          m_fill, m_busy;
  logic [30:0] m_setup;
  bit          m_ovr, m_brk, m_prev;
  logic [9:0]  sb_q[$];
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input bit wr, input logic [7:0] d, input bit pe, input bit fe,
                      input bit brk, input bit swr, input logic [30:0] su,
                      input bit fl, input bit clr, input bit rdy);
    bit pop, pok, acc;
    i_rx_wr = wr; i_rx_data = d; i_rx_parity_err = pe; i_rx_frame_err = fe;
    i_rx_break = brk; i_setup_wr = swr; i_setup = su; i_flush = fl;
    i_clr_status = clr; i_ready = rdy;
    @(posedge i_clk);
    #1;
    pop = (m_fill > 0) && rdy;
    pok = wr && (m_busy == 0);
    acc = pok && (m_fill < 16 || pop);
    if (pok && !acc) m_ovr = 1'b1;
    else if (clr)    m_ovr = 1'b0;
    if (brk && !m_prev) m_brk = 1'b1;
    else if (clr)       m_brk = 1'b0;
    m_prev = brk;
    if (fl) begin
      m_fill = 0;
      sb_q.delete();
    end else begin
      if (acc) sb_q.push_back({fe, pe, d});
      m_fill = m_fill + int'(acc) - int'(pop);
    end
    if (swr) begin
      m_setup = su;
      m_busy  = 2;
    end else if (m_busy > 0) begin
      m_busy--;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) tick(0, 8'h00, 0, 0, 0, 0, 31'd0, 0, 0, rdy);
  endtask

  task automatic push(input logic [7:0] d, input bit pe, input bit fe, input bit rdy);
    tick(1, d, pe, fe, 0, 0, 31'd0, 0, 0, rdy);
  endtask

  // Monitor: compares every cycle and pops the scoreboard on each handshake.
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("fill", 32'(o_fill), 32'(m_fill));
      chk("valid", 32'(o_valid), 32'(m_fill > 0));
      chk("half_full", 32'(o_half_full), 32'(m_fill >= 8));
      chk("overrun", 32'(o_overrun), 32'(m_ovr));
      chk("break_seen", 32'(o_break_seen), 32'(m_brk));
      chk("rx_reset", 32'(o_rx_reset), 32'(m_busy > 0));
      chk("rx_setup", 32'(o_rx_setup), 32'(m_setup));
`ifndef RXUART_CTRL_TIMEOUT_EN
      chk("timeout_off", 32'(o_rx_timeout), 32'd0);
`endif
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_data: got %0h with no expected entry", {o_ferr, o_perr, o_data});
        end else begin
          chk("pop_data", 32'({o_ferr, o_perr, o_data}), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    i_reset = 1'b1;
    i_rx_wr = 0; i_rx_data = 0; i_rx_parity_err = 0; i_rx_frame_err = 0; i_rx_break = 0;
    i_setup_wr = 0; i_setup = 0; i_flush = 0; i_clr_status = 0; i_ready = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_fill", 32'(o_fill), 32'd0);
    chk("rst_data", 32'({o_ferr, o_perr, o_data}), 32'd0);
    chk("rst_half", 32'(o_half_full), 32'd0);
    chk("rst_ovr", 32'(o_overrun), 32'd0);
    chk("rst_brk", 32'(o_break_seen), 32'd0);
    chk("rst_timeout", 32'(o_rx_timeout), 32'd0);
    chk("rst_rx_reset", 32'(o_rx_reset), 32'd1);
    chk("rst_setup", 32'(o_rx_setup), 32'd868);
    i_reset = 1'b0;
    m_fill = 0; m_busy = 2; m_setup = 31'd868; m_ovr = 0; m_brk = 0; m_prev = 0;
    chk_en = 1'b1;

    // Reset window, then one push/pop.
    idle(1, 0);
    chk("rel_rx_reset_hi", 32'(o_rx_reset), 32'd1);
    idle(1, 0);
    chk("rel_rx_reset_lo", 32'(o_rx_reset), 32'd0);
    push(8'h55, 0, 0, 0);
    chk("first_valid", 32'(o_valid), 32'd1);
    chk("first_data", 32'(o_data), 32'h55);
    chk("first_fill", 32'(o_fill), 32'd1);
    idle(1, 1);
    chk("first_pop_fill", 32'(o_fill), 32'd0);

    // Overflow by one, drain, clear status.
    for (int i = 0; i < 17; i++) push(8'(i), 0, 0, 0);
    chk("ovf_fill", 32'(o_fill), 32'd16);
    chk("ovf_half", 32'(o_half_full), 32'd1);
    chk("ovf_overrun", 32'(o_overrun), 32'd1);
    chk("ovf_head", 32'(o_data), 32'h00);
    idle(16, 1);
    chk("ovf_drained", 32'(o_fill), 32'd0);
    tick(0, 8'h00, 0, 0, 0, 0, 31'd0, 0, 1, 0);
    chk("clr_overrun", 32'(o_overrun), 32'd0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 0, 0, 0);
    push(8'hAA, 0, 0, 1);
    chk("pp_fill", 32'(o_fill), 32'd16);
    chk("pp_overrun", 32'(o_overrun), 32'd0);
    idle(15, 1);
    chk("pp_last", 32'(o_data), 32'hAA);
    idle(1, 1);

    // Setup change: writes during the reset window are discarded.
    tick(0, 8'h00, 0, 0, 0, 1, 31'h0000_01B2, 0, 0, 0);
    chk("su_setup", 32'(o_rx_setup), 32'h1B2);
    chk("su_rst1", 32'(o_rx_reset), 32'd1);
    push(8'h77, 0, 0, 0);
    chk("su_rst2", 32'(o_rx_reset), 32'd1);
    push(8'h78, 0, 0, 0);
    chk("su_rst3", 32'(o_rx_reset), 32'd0);
    chk("su_nostore", 32'(o_fill), 32'd0);

    // Error flags, break, flush.
    push(8'h11, 1, 0, 0);
    push(8'h22, 0, 1, 0);
    push(8'h33, 0, 0, 0);
    chk("err_head", 32'({o_ferr, o_perr, o_data}), 32'h111);
    tick(0, 8'h00, 0, 0, 1, 0, 31'd0, 0, 0, 1);
    chk("brk_set", 32'(o_break_seen), 32'd1);
    chk("err_head2", 32'({o_ferr, o_perr, o_data}), 32'h222);
    tick(0, 8'h00, 0, 0, 1, 0, 31'd0, 0, 1, 1);
    chk("brk_clr", 32'(o_break_seen), 32'd0);
    chk("err_head3", 32'({o_ferr, o_perr, o_data}), 32'h033);
    push(8'h44, 0, 0, 0);
    tick(1, 8'h99, 0, 0, 0, 0, 31'd0, 1, 0, 1);
    chk("flush_fill", 32'(o_fill), 32'd0);

`ifdef RXUART_CTRL_TIMEOUT_EN
    tick(0, 8'h00, 0, 0, 0, 1, 31'd16, 0, 0, 0);
    idle(2, 0);
    push(8'h5A, 0, 0, 0);
    idle(255, 0);
    chk("to_before", 32'(o_rx_timeout), 32'd0);
    idle(1, 0);
    chk("to_hit", 32'(o_rx_timeout), 32'd1);
    idle(1, 1);
    chk("to_pop", 32'(o_rx_timeout), 32'd0);
`endif

    // Randomized traffic, phases vary consumer readiness.
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 800; n++) begin
        bit brk_r;
        brk_r = ($urandom_range(0, 15) == 0) ? ~m_prev : m_prev;
        tick($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0, brk_r, $urandom_range(0, 99) == 0,
             31'($urandom), $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) < ph);
      end
    end
    idle(20, 1);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rxuart_ctrl.md
# rxuart_ctrl

Receive-side controller for the `rxuart` deserializer. It owns the line setup word and sequences `rxuart` resets so that setup changes take effect cleanly. It buffers received bytes with their error flags in a FIFO for a valid/ready consumer, and keeps sticky status (overrun, break). It sits between `rxuart` and the bus-facing UART register block.

## Interface
- `LGFLEN`, 4: log2 of FIFO depth (depth = 16 entries).
- `INITIAL_SETUP`, 31'd868: setup word after reset. Same field layout as `rxuart` `i_setup`: [29:28] data bits, [27] double stop, [26] parity enable, [25] fixed parity, [24] even parity, [23:0] clocks per baud.

Ports:
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_setup_wr`  in  1  load `i_setup` into setup register.
- `i_setup`  in  31  new setup word.
- `i_flush`  in  1  discard FIFO contents.
- `i_clr_status`  in  1  clear sticky status bits.
- `o_rx_setup`  out  31  setup word driven to `rxuart`.
- `o_rx_reset`  out  1  reset to `rxuart`.
- `i_rx_wr`, `i_rx_data[7:0]`, `i_rx_break`, `i_rx_parity_err`, `i_rx_frame_err`  in  1/8/1/1/1  `rxuart` outputs.
- `o_valid`  out  1  FIFO head valid.
- `i_ready`  in  1  consumer pops head when `o_valid && i_ready`.
- `o_data`  out  8  head byte.
- `o_perr`, `o_ferr`  out  1  head byte parity/frame error.
- `o_fill`  out  LGFLEN+1  entries held.
- `o_half_full`  out  1  `o_fill >= 2**(LGFLEN-1)`.
- `o_overrun`  out  1  sticky: byte dropped.
- `o_break_seen`  out  1  sticky: break detected.
- `o_rx_timeout`  out  1  idle-timeout flag (see Configuration).

## Operation
- Setup register: reset to `INITIAL_SETUP`. Loaded on `i_setup_wr`. Drives `o_rx_setup` directly.
- Reset sequencer FSM with states IDLE, HOLD, RELEASE:
  - `i_reset` → HOLD.
  - IDLE + `i_setup_wr` → HOLD.
  - HOLD → RELEASE.
  - RELEASE → IDLE.
  - `o_rx_reset` = 1 in HOLD and RELEASE. This gives 2 cycles, so `rxuart` reaches its reset-idle state and relatches setup.
  - `i_setup_wr` while in HOLD/RELEASE reloads the setup register and restarts at HOLD.
  - A byte partially received during a setup change is lost. The FIFO is not flushed.
- FIFO: 10-bit entries {ferr, perr, data}, depth `2**LGFLEN`, pointers wrap modulo depth.
  - Push: `i_rx_wr` while sequencer is IDLE. `i_rx_wr` during HOLD/RELEASE is ignored.
  - Pop: `o_valid && i_ready`.
  - Push when full is accepted only if a pop occurs the same cycle (fill unchanged). Otherwise the byte is dropped and `o_overrun` is set.
  - Simultaneous push and pop when not full: fill unchanged, both take effect.
  - Pop when empty is impossible because `o_valid` = 0.
- `i_flush`: empties the FIFO (pointers and fill to 0). It wins over a same-cycle push and pop. Sticky bits are unaffected.
- `o_break_seen`: set on the rising edge of `i_rx_break` (registered previous value). Cleared by `i_clr_status`; a set event in the same cycle wins.
- `o_overrun`: cleared by `i_clr_status`; a set event in the same cycle wins.

## Timing
- Reset values: `o_valid`=0, `o_fill`=0, `o_data`/`o_perr`/`o_ferr`=0, `o_half_full`=0, `o_overrun`=0, `o_break_seen`=0, `o_rx_timeout`=0, `o_rx_reset`=1 (HOLD), `o_rx_setup`=`INITIAL_SETUP`.
- Push latency: `i_rx_wr` at cycle N → `o_valid`/`o_fill` updated at N+1 (registered; head data valid with `o_valid`).
- Pop: head advances the cycle after the handshake; `o_data` shows the next entry at N+1.
- `i_setup_wr` at N: `o_rx_setup` new at N+1, `o_rx_reset`=1 at N+1 and N+2, 0 at N+3.
- Status flags update one cycle after the causing event.

## Configuration
- `RXUART_CTRL_TIMEOUT_EN` defined:
  - 28-bit counter clears on push, pop, flush, or empty FIFO; otherwise it increments, saturating at {setup[23:0],4'h0} (16 baud periods).
  - `o_rx_timeout` = 1 while the counter is at saturation and the FIFO is non-empty.
- Not defined: counter absent, `o_rx_timeout` tied 0.

## Test plan
- Reset, then setup=868: `o_rx_reset` high 2 cycles after reset deasserts. Push 0x55 → `o_valid`=1, `o_data`=0x55, `o_fill`=1 one cycle later. Pop → `o_fill`=0.
- Push 17 bytes (0x00..0x10) with `i_ready`=0 → `o_fill`=16, `o_half_full`=1, `o_overrun`=1. Drain yields 0x00..0x0F. `i_clr_status` → `o_overrun`=0.
- Full FIFO, push 0xAA and pop in the same cycle → no overrun, `o_fill`=16, 0xAA is the last entry drained.
- `i_setup_wr` with 0x0000_01B2 → `o_rx_setup`=0x1B2 next cycle, `o_rx_reset` high exactly 2 cycles. `i_rx_wr` during that window → not stored.
- Push with `i_rx_parity_err`=1 / `i_rx_frame_err`=1 → `o_perr`/`o_ferr` set for that entry only. `i_rx_break` 0→1 → `o_break_seen`=1. `i_flush` → `o_fill`=0.
- With `RXUART_CTRL_TIMEOUT_EN`, setup=16: one byte held, idle 256 cycles → `o_rx_timeout`=1. Pop → 0 next cycle.
